mdio_arb: RTL and testbench

- Round-robin arbiter/sequencer sharing one MDIO frame engine between NREQ requesters.
- Typical requesters: RX-clock-delay setup engine, link-status poller, host register access.
- Accepts one register command at a time, issues it to the engine, waits for completion, and returns the response to the owning requester.
- Sits between the requesters and the single MDIO master that drives mdc/mdo/mdt.

---
 rtl/mdio_arb_pkg.sv | 14 +
 rtl/mdio_rr_pick.sv | 27 ++
 rtl/mdio_arb.sv | 134 +++++++++++++
 tb/tb_mdio_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_arb_pkg.sv
// Shared types and constants for the MDIO arbiter.
// Optional WAIT timeout is controlled by the MDIO_ARB_TIMEOUT_EN macro.
package mdio_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam int PHYA_W = 5;
   localparam int REGA_W = 5;
   localparam int DATA_W = 16;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   localparam logic [DATA_W-1:0] RDATA_ERR = 16'hFFFF;
endpackage

// File: rtl/mdio_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping at NREQ.
module mdio_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt_onehot,
   output logic [IDW-1:0]  gnt_idx,
   output logic            any
);
   always_comb begin
      int idx;
      idx        = 0;
      any        = 1'b0;
      gnt_idx    = '0;
      gnt_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (!any && req[idx]) begin
            any     = 1'b1;
            gnt_idx = IDW'(idx);
         end
      end
      if (any) gnt_onehot[gnt_idx] = 1'b1;
   end
endmodule

// File: rtl/mdio_arb.sv
// Round-robin sequencer sharing one MDIO frame engine among NREQ requesters.
// Define MDIO_ARB_TIMEOUT_EN to bound the WAIT state to TMO cycles.
module mdio_arb
   import mdio_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TMO  = 4096,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_wr,
   input  logic [PHYA_W*NREQ-1:0] req_phya,
   input  logic [REGA_W*NREQ-1:0] req_rega,
   input  logic [DATA_W*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic                   m_start,
   output logic                   m_wr,
   output logic [PHYA_W-1:0]      m_phya,
   output logic [REGA_W-1:0]      m_rega,
   output logic [DATA_W-1:0]      m_wdata,
   input  logic                   m_done,
   input  logic [DATA_W-1:0]      m_rdata,
   output logic                   busy,
   output logic [IDW-1:0]         grant_id
);
   state_t              state_q, state_d;
   logic [IDW-1:0]      rr_ptr, gid;
   logic                wr_q;
   logic [PHYA_W-1:0]   phya_q;
   logic [REGA_W-1:0]   rega_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [NREQ-1:0]     gnt_onehot;
   logic [IDW-1:0]      gnt_idx;
   logic                any;
   logic                tmo_hit;

   mdio_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req        (req_valid),
      .ptr        (rr_ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (any)
   );

`ifdef MDIO_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TMO) > 13) ? $clog2(TMO) : 13;
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   // m_done wins over a coincident timeout because it is tested first below
   assign tmo_hit = (state_q == WAIT) && (tmo_cnt == CNT_W'(TMO - 1));
   assign rsp_err = err_q;

   always_ff @(posedge clk) begin
      if (rst)                  tmo_cnt <= '0;
      else if (state_q == ISSUE) tmo_cnt <= '0;
      else if (state_q == WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (m_done || tmo_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         gid     <= '0;
         wr_q    <= OP_RD;
         phya_q  <= '0;
         rega_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         if (state_q == IDLE && any) begin
            gid     <= gnt_idx;
            wr_q    <= req_wr[gnt_idx];
            phya_q  <= req_phya[int'(gnt_idx)*PHYA_W +: PHYA_W];
            rega_q  <= req_rega[int'(gnt_idx)*REGA_W +: REGA_W];
            wdata_q <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
         end
         if (state_q == WAIT) begin
            if (m_done) begin
               rdata_q <= (wr_q == OP_WR) ? '0 : m_rdata;
`ifdef MDIO_ARB_TIMEOUT_EN
               err_q   <= 1'b0;
`endif
            end else if (tmo_hit) begin
               rdata_q <= RDATA_ERR;
`ifdef MDIO_ARB_TIMEOUT_EN
               err_q   <= 1'b1;
`endif
            end
         end
         if (state_q == RESP)
            rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
      end
   end

   // Accept is combinational so the winner sees its ready in the cycle it is chosen
   assign req_ready = (state_q == IDLE && !rst) ? gnt_onehot : '0;
   assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << gid) : '0;
   assign rsp_rdata = rdata_q;
   assign m_start   = (state_q == ISSUE);
   assign m_wr      = wr_q;
   assign m_phya    = phya_q;
   assign m_rega    = rega_q;
   assign m_wdata   = wdata_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = gid;
endmodule

// File: tb/tb_mdio_arb.sv
// Self-checking bench for mdio_arb: directed and randomized commands against a
// round-robin reference model; the timeout section runs when MDIO_ARB_TIMEOUT_EN is set.
module tb_mdio_arb;
   import mdio_arb_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
`ifdef MDIO_ARB_TIMEOUT_EN
   localparam int TMO  = 64;
`else
   localparam int TMO  = 4096;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid, req_ready, req_wr, rsp_valid;
   logic [5*NREQ-1:0]      req_phya, req_rega;
   logic [16*NREQ-1:0]     req_wdata;
   logic [15:0]            rsp_rdata, m_wdata, m_rdata;
   logic                   rsp_err, m_start, m_wr, m_done, busy;
   logic [4:0]             m_phya, m_rega;
   logic [IDW-1:0]         grant_id;

   always #5 clk = ~clk;

   mdio_arb #(.NREQ(NREQ), .TMO(TMO), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_phya(req_phya), .req_rega(req_rega), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_start(m_start), .m_wr(m_wr), .m_phya(m_phya), .m_rega(m_rega),
      .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;
   int grants[$];

   logic        f_wr[NREQ];
   logic [4:0]  f_phya[NREQ];
   logic [4:0]  f_rega[NREQ];
   logic [15:0] f_wdata[NREQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Spec rule: first valid index searching upward from the pointer, with wrap
   function automatic int pick(input logic [NREQ-1:0] mask, input int ptr);
      for (int i = 0; i < NREQ; i++)
         if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_fields();
      for (int i = 0; i < NREQ; i++) begin
         f_wr[i]    = 1'($urandom_range(0, 1));
         f_phya[i]  = 5'($urandom);
         f_rega[i]  = 5'($urandom);
         f_wdata[i] = 16'($urandom);
      end
   endtask

   task automatic drive_fields();
      for (int i = 0; i < NREQ; i++) begin
         req_wr[i]            = f_wr[i];
         req_phya[5*i +: 5]   = f_phya[i];
         req_rega[5*i +: 5]   = f_rega[i];
         req_wdata[16*i +: 16] = f_wdata[i];
      end
   endtask

   // One full command: accept, issue, engine completes k cycles after m_start, response
   task automatic txn(input logic [NREQ-1:0] mask, input int k, input logic [15:0] rd);
      int g;
      logic [15:0] exp_rd;
      g = pick(mask, model_ptr);
      drive_fields();
      req_valid = mask;
      #1;
      chk("ready_onehot", 32'(req_ready), 32'(1) << g);
      chk("busy_idle", 32'(busy), 32'd0);
      step();
      chk("m_start", 32'(m_start), 32'd1);
      chk("grant_id", 32'(grant_id), 32'(g));
      chk("m_wr", 32'(m_wr), 32'(f_wr[g]));
      chk("m_phya", 32'(m_phya), 32'(f_phya[g]));
      chk("m_rega", 32'(m_rega), 32'(f_rega[g]));
      chk("m_wdata", 32'(m_wdata), 32'(f_wdata[g]));
      chk("ready_after_accept", 32'(req_ready), 32'd0);
      for (int j = 0; j < k; j++) begin
         m_rdata = 16'($urandom);
         step();
         if (j == 0) chk("m_start_one_cycle", 32'(m_start), 32'd0);
      end
      m_done  = 1'b1;
      m_rdata = rd;
      step();
      m_done  = 1'b0;
      m_rdata = 16'($urandom);
      exp_rd  = f_wr[g] ? 16'h0000 : rd;
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << g);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      chk("rsp_err", 32'(rsp_err), 32'd0);
      chk("m_phya_hold", 32'(m_phya), 32'(f_phya[g]));
      req_valid = '0;
      step();
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      chk("busy_back_idle", 32'(busy), 32'd0);
      model_ptr = (g + 1) % NREQ;
      grants.push_back(g);
   endtask

   initial begin
      logic [NREQ-1:0] mask;
      rst = 1'b1; req_valid = '0; req_wr = '0; req_phya = '0; req_rega = '0;
      req_wdata = '0; m_done = 1'b0; m_rdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         f_wr[i] = 1'b0; f_phya[i] = '0; f_rega[i] = '0; f_wdata[i] = '0;
      end
      step(); step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_m_start", 32'(m_start), 32'd0);
      chk("rst_m_fields", {m_wr, m_phya, m_rega, m_wdata}, 32'd0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      step();

      // spurious engine completion while idle
      m_done = 1'b1; m_rdata = 16'h1234;
      step();
      m_done = 1'b0;
      chk("spurious_busy", 32'(busy), 32'd0);
      step();
      chk("spurious_rsp", 32'(rsp_valid), 32'd0);

      // directed read by requester 1
      rand_fields();
      f_wr[1] = OP_RD; f_phya[1] = 5'd2; f_rega[1] = 5'd3;
      txn(4'b0010, 200, 16'hA5A5);

      // directed write by requester 0
      rand_fields();
      f_wr[0] = OP_WR; f_phya[0] = 5'd1; f_rega[0] = 5'h14; f_wdata[0] = 16'h0C01;
      txn(4'b0001, 7, 16'hBEEF);

      // reset while waiting on the engine abandons the command
      rand_fields();
      drive_fields();
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      for (int j = 0; j < 5; j++) step();
      chk("abort_busy_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      chk("abort_rst_busy", 32'(busy), 32'd0);
      chk("abort_rst_rsp", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      m_done = 1'b1; m_rdata = 16'h5555;
      step();
      m_done = 1'b0;
      step();
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      model_ptr = 0;

      // fairness: every requester valid on every grant
      grants.delete();
      for (int n = 0; n < 6; n++) begin
         rand_fields();
         txn(4'b1111, 10, 16'($urandom));
      end
      for (int n = 0; n < 6; n++) chk("fair_order", 32'(grants[n]), 32'(n % NREQ));

      // skip: after grant 2 only 0 and 3 are valid
      rand_fields();
      txn(4'b0100, 3, 16'($urandom));
      grants.delete();
      rand_fields();
      txn(4'b1001, 2, 16'($urandom));
      rand_fields();
      txn(4'b1001, 1, 16'($urandom));
      chk("skip_first", 32'(grants[0]), 32'd3);
      chk("skip_second", 32'(grants[1]), 32'd0);

      // randomized masks, latencies and fields
      for (int n = 0; n < 25; n++) begin
         rand_fields();
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         txn(mask, $urandom_range(1, 15), 16'($urandom));
      end

`ifdef MDIO_ARB_TIMEOUT_EN
      // engine never answers: error response exactly TMO cycles into WAIT
      begin
         int g;
         rand_fields();
         drive_fields();
         mask = 4'b0110;
         g = pick(mask, model_ptr);
         req_valid = mask;
         step();
         req_valid = '0;
         chk("tmo_m_start", 32'(m_start), 32'd1);
         for (int j = 0; j < TMO; j++) begin
            step();
            if (rsp_valid !== '0) chk("tmo_early_rsp", 32'(rsp_valid), 32'd0);
         end
         step();
         chk("tmo_rsp_valid", 32'(rsp_valid), 32'(1) << g);
         chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
         chk("tmo_rsp_rdata", 32'(rsp_rdata), 32'hFFFF);
         step();
         m_done = 1'b1;
         step();
         m_done = 1'b0;
         chk("tmo_late_done_busy", 32'(busy), 32'd0);
         step();
         chk("tmo_late_done_rsp", 32'(rsp_valid), 32'd0);
         model_ptr = (g + 1) % NREQ;
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
